// File: rtl/tank_level_encoder.sv
// Tank level encoder: synchronizes and debounces three float switches,
// validates the thermometer code and presents a registered 2-bit level
// with valid / fault / change indications.

// One switch lane: 2-flop synchronizer followed by a disagreement counter.
module tle_lane #(
  parameter int DEB_CYCLES = 1000,
  parameter int TMR_W      = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic deb
);
  logic [1:0]       sync;
  logic [TMR_W-1:0] cnt;

  // Bring the asynchronous switch into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], sw};
  end

  // Flip the debounced bit only after DEB_CYCLES consecutive disagreements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync[1] == deb) begin
      cnt <= '0;
    end else if (cnt == TMR_W'(DEB_CYCLES - 1)) begin
      deb <= ~deb;
      cnt <= '0;
    end else begin
      cnt <= cnt + TMR_W'(1);
    end
  end
endmodule

module tank_level_encoder #(
  parameter int DEB_CYCLES   = 1000,
  parameter int FAULT_CYCLES = 4000,
  parameter int TMR_W        = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic S_low,
  input  logic S_mid,
  input  logic S_high,
  output logic Nv1,
  output logic Nv0,
  output logic Valid,
  output logic Fault,
  output logic Chg
);
  localparam int NUM_LANES = 3;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HOLD, ST_FAULT} state_t;

  logic [NUM_LANES-1:0] sw;
  logic [NUM_LANES-1:0] code;   // {high, mid, low}
  logic                 legal;
  logic [1:0]           enc;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [1:0]       nv, nv_nxt;

  assign sw = {S_high, S_mid, S_low};

  tle_lane #(.DEB_CYCLES(DEB_CYCLES), .TMR_W(TMR_W)) u_lane [NUM_LANES-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .deb  (code)
  );

  // Thermometer decode: only 000/001/011/111 are physically possible.
  always_comb begin
    legal = 1'b1;
    enc   = 2'b00;
    case (code)
      3'b000:  enc = 2'b00;
      3'b001:  enc = 2'b01;
      3'b011:  enc = 2'b10;
      3'b111:  enc = 2'b11;
      default: legal = 1'b0;
    endcase
  end

  // Next state, shared timer and level value.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    nv_nxt    = nv;
    case (state)
      ST_INIT: begin
        timer_nxt = timer + TMR_W'(1);
        if (timer == TMR_W'(DEB_CYCLES - 1)) begin
          timer_nxt = '0;
          if (legal) begin
            state_nxt = ST_RUN;
            nv_nxt    = enc;
          end else begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_RUN: begin
        if (legal) begin
          nv_nxt = enc;
        end else begin
          state_nxt = ST_HOLD;
          timer_nxt = '0;
        end
      end
      ST_HOLD: begin
        if (legal) begin
          state_nxt = ST_RUN;
          nv_nxt    = enc;
          timer_nxt = '0;
        end else if (timer == TMR_W'(FAULT_CYCLES - 1)) begin
          state_nxt = ST_FAULT;
          nv_nxt    = 2'b00;  // safe level: no irrigation
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      ST_FAULT: begin
        nv_nxt = 2'b00;
        if (legal) begin
          state_nxt = ST_RUN;
          nv_nxt    = enc;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        timer_nxt = '0;
        nv_nxt    = 2'b00;
      end
    endcase
  end

  // Register state and every output; Chg marks the first cycle of a new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      timer <= '0;
      nv    <= 2'b00;
      Valid <= 1'b0;
      Fault <= 1'b0;
      Chg   <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      nv    <= nv_nxt;
      Valid <= (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
      Fault <= (state_nxt == ST_FAULT);
      Chg   <= (nv_nxt != nv);
    end
  end

  assign Nv1 = nv[1];
  assign Nv0 = nv[0];
endmodule

// File: tb/tb_tank_level_encoder.sv
// Scoreboard bench for tank_level_encoder with DEB_CYCLES=4, FAULT_CYCLES=8.
// Stimulus pushes the expected level update (cycle and output values) for
// every Chg pulse; the monitor pops and compares whenever Chg is seen.
module tb_tank_level_encoder;
  logic clk, rst_n, S_low, S_mid, S_high;
  logic Nv1, Nv0, Valid, Fault, Chg;

  tank_level_encoder #(.DEB_CYCLES(4), .FAULT_CYCLES(8), .TMR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .S_low(S_low), .S_mid(S_mid), .S_high(S_high),
    .Nv1(Nv1), .Nv0(Nv0), .Valid(Valid), .Fault(Fault), .Chg(Chg)
  );

  typedef struct {
    int         cyc;
    logic [1:0] nv;
    logic       valid;
    logic       fault;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every Chg pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (q.size() != 0 && cyc > q[0].cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL chg_missing: no Chg seen at cycle %0d (now %0d), required nv=%b valid=%b fault=%b",
               q[0].cyc, cyc, q[0].nv, q[0].valid, q[0].fault);
      void'(q.pop_front());
    end
    if (Chg) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL chg_unexpected: Chg at cycle %0d with nv=%b valid=%b fault=%b, none required",
                 cyc, {Nv1, Nv0}, Valid, Fault);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || {Nv1, Nv0} != e.nv || Valid != e.valid || Fault != e.fault) begin
          n_fail++;
          $display("FAIL chg_update: got cyc=%0d nv=%b valid=%b fault=%b, required cyc=%0d nv=%b valid=%b fault=%b",
                   cyc, {Nv1, Nv0}, Valid, Fault, e.cyc, e.nv, e.valid, e.fault);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic set_sw(input logic [2:0] v);
    {S_high, S_mid, S_low} = v;
  endtask

  task automatic push(input int c, input logic [1:0] nv, input logic v, input logic f);
    exp_t x;
    x.cyc = c; x.nv = nv; x.valid = v; x.fault = f;
    q.push_back(x);
  endtask

  // Directed check of {Nv1,Nv0,Valid,Fault,Chg}.
  task automatic chk(input string name, input logic [4:0] req);
    n_chk++;
    if ({Nv1, Nv0, Valid, Fault, Chg} !== req) begin
      n_fail++;
      $display("FAIL %s: got {nv,valid,fault,chg}=%b required %b at cycle %0d",
               name, {Nv1, Nv0, Valid, Fault, Chg}, req, cyc);
    end
  endtask

  // Sample at cycle c, well clear of the rising edge.
  task automatic chk_at(input int c, input string name, input logic [4:0] req);
    wait_cyc(c);
    #3;
    chk(name, req);
  endtask

  int n, r;

  initial begin
    rst_n = 1'b0;
    set_sw(3'b000);

    // 1. Power-up
    tick(3);
    #3 chk("reset_state", 5'b00000);
    rst_n = 1'b1;
    r = cyc;
    chk_at(r + 3, "init_not_valid", 5'b00000);
    chk_at(r + 4, "valid_rise", 5'b00100);
    tick(5);

    // 2. Fill sequence
    n = cyc; set_sw(3'b001); push(n + 7, 2'b01, 1'b1, 1'b0); tick(20);
    n = cyc; set_sw(3'b011); push(n + 7, 2'b10, 1'b1, 1'b0); tick(20);
    n = cyc; set_sw(3'b111); push(n + 7, 2'b11, 1'b1, 1'b0); tick(20);
    // All three switches drop together: one step straight to empty.
    n = cyc; set_sw(3'b000); push(n + 7, 2'b00, 1'b1, 1'b0); tick(20);

    // 3. Bounce rejection on S_low
    for (int i = 0; i < 6; i++) begin
      S_low = 1'b1; tick(3);
      S_low = 1'b0; tick(2);
    end
    n = cyc; S_low = 1'b1; push(n + 7, 2'b01, 1'b1, 1'b0); tick(20);

    // 4. Fault
    n = cyc; set_sw(3'b011); push(n + 7, 2'b10, 1'b1, 1'b0); tick(20);
    n = cyc; set_sw(3'b010);
    push(n + 15, 2'b00, 1'b0, 1'b1);
    chk_at(n + 14, "hold_before_fault", 5'b10100);
    wait_cyc(n + 25);
    n = cyc; set_sw(3'b011); push(n + 7, 2'b10, 1'b1, 1'b0); tick(20);

    // 5. Transient skew
    n = cyc; set_sw(3'b001); push(n + 7, 2'b01, 1'b1, 1'b0); tick(20);
    n = cyc; set_sw(3'b100); tick(6);
    set_sw(3'b111); push(n + 13, 2'b11, 1'b1, 1'b0);
    chk_at(n + 10, "transient_hold", 5'b01100);
    tick(20);

    // 6. Reset mid-debounce
    set_sw(3'b011); tick(4);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 5'b00000);
    set_sw(3'b000);
    tick(3);
    rst_n = 1'b1;
    r = cyc;
    chk_at(r + 3, "reinit_not_valid", 5'b00000);
    chk_at(r + 4, "revalid_rise", 5'b00100);
    tick(12);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d updates outstanding, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
